my_mc_ctrl: RTL
===============

# my_mc_ctrl

Multi-cycle sequencer for the RV32 datapath, which shares one single-port memory between instruction fetch and data access. It steps each instruction through FETCH/DECODE/EXEC/MEM/WB and issues the datapath's existing control set (ALU_Control, ImmSel, MemtoReg, ALUSrc_B, Jump, Branch, InverseBranch, RegWrite). It also drives the multi-cycle additions: PC_write, IR_write and a ready-handshaked memory request. It sits between the instruction register and the datapath, replacing the combinational single-cycle decoder.

## Interface
Parameters: none.
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset (0 = reset)
- opcode  in  7  IR[6:0], held stable by IR from DECODE onward
- funct3  in  3  IR[14:12]
- funct7_5  in  1  IR[30]
- mem_ready  in  1  memory completes the current request this cycle
- mem_req  out  1  memory request, held until mem_ready
- mem_we  out  1  1 = store, valid only with mem_req
- mem_sel_data  out  1  0 = address PC (fetch), 1 = address ALU_out (data)
- IR_write  out  1  latch fetched word into IR
- PC_write  out  1  load pc_next into PC
- ALU_Control  out  4  ADD 0010, SUB 0110, AND 0000, OR 0001, XOR 0011, SLT 0111, SLL 1001, SRL 0101, SRA 1101
- ImmSel  out  2  00 I, 01 S, 10 SB, 11 UJ
- MemtoReg  out  2  0 ALU, 1 memory, 2 PC+4
- ALUSrc_B, Jump, Branch, InverseBranch, RegWrite  out  1 each  datapath controls
- illegal  out  1  sticky unsupported-opcode flag
- state  out  3  FSM state, for debug
- cycle_cnt, retire_cnt  out  32 each  performance counters (see Configuration)

## Operation
- States: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=5. Encodings 6 and 7 go to FETCH.
- FETCH: mem_req=1, mem_sel_data=0, mem_we=0. On mem_ready: IR_write=1 in that cycle, go to DECODE. Otherwise stay.
- DECODE: no side effects. Go to EXEC for supported opcodes, TRAP otherwise.
- EXEC, by opcode:
  - R 0110011: ALUSrc_B=0. ALU_Control from {funct7_5, funct3} (add/sub/and/or/xor/slt/sll/srl/sra). Go to WB.
  - I-ALU 0010011: ALUSrc_B=1, ImmSel=00. funct7_5 is used only for srai. Go to WB.
  - load 0000011 / store 0100011: ADD, ALUSrc_B=1, ImmSel=00 (load) or 01 (store). Go to MEM.
  - branch 1100011 (beq funct3=000, bne 001): SUB, Branch=1, InverseBranch=funct3[0], ImmSel=10, PC_write=1. Retire, go to FETCH. Other funct3 values go to TRAP.
  - jal 1101111: ImmSel=11, Jump=1, RegWrite=1, MemtoReg=2, PC_write=1. Retire, go to FETCH.
- MEM: mem_req=1, mem_sel_data=1, mem_we=1 for store. ALU controls are held from EXEC so the address stays stable.
  - On mem_ready, store: PC_write=1, retire, go to FETCH.
  - On mem_ready, load: go to WB.
- WB: RegWrite=1, PC_write=1 (Jump=Branch=0, so PC+4). MemtoReg=1 for load, 0 otherwise. ALU controls are held for R/I. Retire, go to FETCH.
- TRAP: illegal=1, all strobes 0, stays in TRAP until reset.
- Every control output not listed for a state is 0.

## Timing
- Outputs are decoded from registered state plus the IR inputs, with no input-to-output path except mem_ready → IR_write/PC_write in the wait states.
- During reset: state=FETCH, all outputs 0, illegal=0, counters 0. mem_req rises in the first cycle after rst deasserts.
- mem_ready may arrive in the same cycle as mem_req (zero wait). With zero wait states, CPI is: branch/jal 3, R/I/store 4, load 5. Each memory wait cycle adds 1.
- mem_req and mem_sel_data stay constant while waiting. mem_ready when mem_req=0 is ignored.
- Exactly one PC_write per retired instruction, never in FETCH/DECODE/TRAP.
- Reset asserted mid-wait clears state and drops mem_req and every strobe immediately (asynchronous).

## Configuration
- MC_CTRL_PERF_EN defined:
  - cycle_cnt increments every cycle out of reset, except in TRAP.
  - retire_cnt increments on each retire cycle.
  - Both wrap at 2^32 to 0.
- MC_CTRL_PERF_EN undefined: both ports are tied to 0 and no counter registers are built.

## Test plan
- Reset, zero-wait memory, `add x3,x1,x2` (0x002081B3) → states 0,1,2,4. IR_write in cycle 0; RegWrite=PC_write=1 only in cycle 3; ALU_Control=0010.
- `lw` (0x0000A183) with mem_ready low for 2 extra cycles in MEM → mem_req/mem_sel_data=1 held 3 cycles. WB has MemtoReg=1; total 7 cycles.
- `bne` (0x00209463) → EXEC has Branch=1, InverseBranch=1, ImmSel=10, PC_write=1; retires after 3 cycles.
- `jal x1` (0x008000EF) → EXEC has Jump=1, RegWrite=1, MemtoReg=2, ImmSel=11.
- Opcode 0x7F → TRAP after DECODE; illegal=1; no PC_write for 10 cycles; rst low clears to FETCH.
- rst pulsed low during a FETCH wait → mem_req=0 in the same cycle. With MC_CTRL_PERF_EN, cycle_cnt=0 and retire_cnt=0 after reset, and retire_cnt=2 after add plus bne.

Source files
------------

// File: rtl/my_mc_ctrl_if.sv
// my_mc_ctrl_if: IR fields, shared-memory handshake and datapath controls around the multi-cycle sequencer.
// slave = sequencer side, master = IR/memory/datapath side.
interface my_mc_ctrl_if;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic        funct7_5;
  logic        mem_ready;
  logic        mem_req;
  logic        mem_we;
  logic        mem_sel_data;
  logic        IR_write;
  logic        PC_write;
  logic [3:0]  ALU_Control;
  logic [1:0]  ImmSel;
  logic [1:0]  MemtoReg;
  logic        ALUSrc_B;
  logic        Jump;
  logic        Branch;
  logic        InverseBranch;
  logic        RegWrite;
  logic        illegal;
  logic [2:0]  state;
  logic [31:0] cycle_cnt;
  logic [31:0] retire_cnt;

  modport slave (
    input  opcode, funct3, funct7_5, mem_ready,
    output mem_req, mem_we, mem_sel_data, IR_write, PC_write, ALU_Control, ImmSel, MemtoReg,
           ALUSrc_B, Jump, Branch, InverseBranch, RegWrite, illegal, state, cycle_cnt, retire_cnt
  );

  modport master (
    output opcode, funct3, funct7_5, mem_ready,
    input  mem_req, mem_we, mem_sel_data, IR_write, PC_write, ALU_Control, ImmSel, MemtoReg,
           ALUSrc_B, Jump, Branch, InverseBranch, RegWrite, illegal, state, cycle_cnt, retire_cnt
  );
endinterface

// File: rtl/my_mc_ctrl.sv
// my_mc_ctrl: FETCH/DECODE/EXEC/MEM/WB sequencer for an RV32 datapath sharing one single-port memory.
// Define MC_CTRL_PERF_EN to build the cycle/retire performance counters.
module my_mc_ctrl (
  input  logic        clk,
  input  logic        rst,
  my_mc_ctrl_if.slave bus
);
  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_MEM    = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;
  localparam logic [2:0] S_TRAP   = 3'd5;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LD  = 7'b0000011;
  localparam logic [6:0] OP_ST  = 7'b0100011;
  localparam logic [6:0] OP_BR  = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_XOR = 4'b0011;
  localparam logic [3:0] ALU_SRL = 4'b0101;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_SLL = 4'b1001;
  localparam logic [3:0] ALU_SRA = 4'b1101;

  logic [2:0] r_state;
  logic [2:0] w_next;
  logic       w_is_r, w_is_i, w_is_ld, w_is_st, w_is_br, w_is_jal, w_br_ok, w_supported, w_alu_hold;
  logic [3:0] w_alu_op;
  logic       w_mem_req, w_mem_we, w_mem_sel, w_ir_write, w_pc_write, w_reg_write;
  logic       w_src_b, w_jump, w_branch, w_inv, w_illegal;
  logic [1:0] w_imm_sel, w_mem_to_reg;
  logic [3:0] w_alu_ctl;

  // funct7_5 only selects SUB for R-type; for shifts it picks SRA in both R and I forms.
  function automatic logic [3:0] alu_decode(input logic is_r, input logic [2:0] f3, input logic f75);
    logic [3:0] res;
    case (f3)
      3'b000:  res = (is_r && f75) ? ALU_SUB : ALU_ADD;
      3'b001:  res = ALU_SLL;
      3'b010:  res = ALU_SLT;
      3'b100:  res = ALU_XOR;
      3'b101:  res = f75 ? ALU_SRA : ALU_SRL;
      3'b110:  res = ALU_OR;
      3'b111:  res = ALU_AND;
      default: res = ALU_ADD;
    endcase
    return res;
  endfunction

  assign w_is_r      = (bus.opcode == OP_R);
  assign w_is_i      = (bus.opcode == OP_I);
  assign w_is_ld     = (bus.opcode == OP_LD);
  assign w_is_st     = (bus.opcode == OP_ST);
  assign w_is_br     = (bus.opcode == OP_BR);
  assign w_is_jal    = (bus.opcode == OP_JAL);
  assign w_br_ok     = w_is_br && (bus.funct3[2:1] == 2'b00);
  assign w_supported = w_is_r || w_is_i || w_is_ld || w_is_st || w_is_br || w_is_jal;
  assign w_alu_op    = alu_decode(w_is_r, bus.funct3, bus.funct7_5);

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_FETCH;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state decode
  always_comb begin
    w_next = S_FETCH;
    case (r_state)
      S_FETCH:  w_next = bus.mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: w_next = w_supported ? S_EXEC : S_TRAP;
      S_EXEC: begin
        if (w_is_ld || w_is_st)    w_next = S_MEM;
        else if (w_is_r || w_is_i) w_next = S_WB;
        else if (w_br_ok || w_is_jal) w_next = S_FETCH;
        else                       w_next = S_TRAP;
      end
      S_MEM:    w_next = bus.mem_ready ? (w_is_st ? S_FETCH : S_WB) : S_MEM;
      S_WB:     w_next = S_FETCH;
      S_TRAP:   w_next = S_TRAP;
      default:  w_next = S_FETCH;
    endcase
  end

  // Output decode; everything is forced low while reset is held
  always_comb begin
    w_mem_req = 1'b0; w_mem_we = 1'b0; w_mem_sel = 1'b0; w_ir_write = 1'b0; w_pc_write = 1'b0;
    w_reg_write = 1'b0; w_src_b = 1'b0; w_jump = 1'b0; w_branch = 1'b0; w_inv = 1'b0;
    w_illegal = 1'b0; w_imm_sel = 2'b00; w_mem_to_reg = 2'b00; w_alu_ctl = 4'b0000; w_alu_hold = 1'b0;
    if (!rst) begin
      w_alu_hold = 1'b0;
    end else begin
      case (r_state)
        S_FETCH: begin
          w_mem_req  = 1'b1;
          w_ir_write = bus.mem_ready;
        end
        S_DECODE: w_alu_hold = 1'b0;
        S_EXEC: begin
          w_alu_hold = 1'b1;
          if (w_br_ok) begin
            w_pc_write = 1'b1; w_branch = 1'b1; w_inv = bus.funct3[0];
          end else if (w_is_jal) begin
            w_pc_write = 1'b1; w_jump = 1'b1; w_reg_write = 1'b1; w_mem_to_reg = 2'd2;
          end else begin
            w_jump = 1'b0;
          end
        end
        S_MEM: begin
          w_alu_hold = 1'b1;
          w_mem_req  = 1'b1;
          w_mem_sel  = 1'b1;
          w_mem_we   = w_is_st;
          w_pc_write = w_is_st && bus.mem_ready;
        end
        S_WB: begin
          w_alu_hold   = w_is_r || w_is_i;
          w_reg_write  = 1'b1;
          w_pc_write   = 1'b1;
          w_mem_to_reg = {1'b0, w_is_ld};
        end
        S_TRAP:  w_illegal = 1'b1;
        default: w_illegal = 1'b0;
      endcase
      // ALU/immediate selection stays put from EXEC through MEM/WB so the address and operands hold
      if (w_alu_hold) begin
        if (w_is_r || w_is_i)       w_alu_ctl = w_alu_op;
        else if (w_is_ld || w_is_st) w_alu_ctl = ALU_ADD;
        else if (w_br_ok)           w_alu_ctl = ALU_SUB;
        else                        w_alu_ctl = 4'b0000;
        w_src_b = w_is_i || w_is_ld || w_is_st;
        if (w_is_st)       w_imm_sel = 2'b01;
        else if (w_br_ok)  w_imm_sel = 2'b10;
        else if (w_is_jal) w_imm_sel = 2'b11;
        else               w_imm_sel = 2'b00;
      end else begin
        w_alu_ctl = 4'b0000;
      end
    end
  end

  assign bus.state         = r_state;
  assign bus.mem_req       = w_mem_req;
  assign bus.mem_we        = w_mem_we;
  assign bus.mem_sel_data  = w_mem_sel;
  assign bus.IR_write      = w_ir_write;
  assign bus.PC_write      = w_pc_write;
  assign bus.ALU_Control   = w_alu_ctl;
  assign bus.ImmSel        = w_imm_sel;
  assign bus.MemtoReg      = w_mem_to_reg;
  assign bus.ALUSrc_B      = w_src_b;
  assign bus.Jump          = w_jump;
  assign bus.Branch        = w_branch;
  assign bus.InverseBranch = w_inv;
  assign bus.RegWrite      = w_reg_write;
  assign bus.illegal       = w_illegal;

`ifdef MC_CTRL_PERF_EN
  logic [31:0] r_cycle_cnt;
  logic [31:0] r_retire_cnt;

  // Performance counters; a retire is exactly the cycle carrying PC_write
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cycle_cnt  <= 32'd0;
      r_retire_cnt <= 32'd0;
    end else begin
      if (r_state != S_TRAP) r_cycle_cnt <= r_cycle_cnt + 32'd1;
      else                   r_cycle_cnt <= r_cycle_cnt;
      if (w_pc_write) r_retire_cnt <= r_retire_cnt + 32'd1;
      else            r_retire_cnt <= r_retire_cnt;
    end
  end

  assign bus.cycle_cnt  = r_cycle_cnt;
  assign bus.retire_cnt = r_retire_cnt;
`else
  assign bus.cycle_cnt  = 32'd0;
  assign bus.retire_cnt = 32'd0;
`endif
endmodule
